router_buffered: RTL and testbench
==================================

Name: router_buffered

Overview:
- Parametrised 1-to-N stream router with an independent FIFO per output channel.
- Removes head-of-line blocking: a stalled output does not block traffic to other outputs while its FIFO has space.
- Adds a configurable select-field position, optional broadcast, and drop-with-count for out-of-range destinations.
- Sits between a single producer (e.g. a deserializer) and N downstream processing lanes.

Parameters:
- nbits, 32, message width.
- noutputs, 8, number of output channels; must be >= 2; need not be a power of two.
- qdepth, 4, entries per output FIFO; must be >= 2.
- sel_lsb, nbits-$clog2(noutputs), LSB of the select field (width SW=$clog2(noutputs)); sel_lsb+SW <= nbits.
- bcast_en, 1, 1 enables broadcast.
- bcast_bit, nbits-$clog2(noutputs)-1, message bit that requests broadcast; must lie outside the select field.
- cnt_nbits, 16, width of drop_count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- istream_val  input  1  input message valid.
- istream_msg  input  nbits  input message.
- istream_rdy  output  1  input ready.
- ostream_val  output  1 x [0:noutputs-1]  per-output valid.
- ostream_msg  output  nbits x [0:noutputs-1]  per-output message, unmodified from input.
- ostream_rdy  input  1 x [0:noutputs-1]  per-output ready.
- drop_count  output  cnt_nbits  saturating count of dropped messages.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset state:
  - All FIFOs empty (head, tail, count = 0).
  - drop_count = 0.
  - All ostream_val = 0.
  - istream_rdy is driven combinationally and follows the rules below; with FIFOs empty it is 1.
- Decode (combinational):
  - sel = istream_msg[sel_lsb +: SW].
  - bcast = bcast_en && istream_msg[bcast_bit].
- istream_rdy (combinational from istream_msg and FIFO state only, never from istream_val):
  - bcast: 1 iff every FIFO has count < qdepth.
  - else if sel < noutputs: 1 iff FIFO[sel] count < qdepth.
  - else (out-of-range): 1, and the message is discarded.
- Accept: a transfer occurs on the edge where istream_val && istream_rdy.
  - Unicast: write FIFO[sel].
  - Broadcast: write all FIFOs in the same cycle (all-or-nothing, never partial).
  - Out-of-range: no FIFO written; drop_count += 1, saturating at 2^cnt_nbits-1. Broadcast takes precedence over select decoding.
- Full FIFO: no enqueue even if it dequeues that same cycle (no pass-through-on-full). The freed slot is visible to istream_rdy the next cycle.
- Output side, per channel i:
  - ostream_val[i] = (count[i] != 0).
  - ostream_msg[i] = FIFO[i] head entry; don't-care when empty, but must be stable while val=1 and rdy=0.
  - Dequeue when ostream_val[i] && ostream_rdy[i].
- Latency: minimum 1 cycle. A message accepted on edge N is visible at the output after edge N, with no combinational input-to-output bypass.
- Simultaneous enqueue and dequeue on a non-full, non-empty FIFO: count unchanged; head and tail both advance.
- Empty FIFO with enqueue: val rises the next cycle.
- Pointers wrap modulo qdepth; qdepth need not be a power of two.
- Ordering: each output sees its messages in input order; no ordering is defined across outputs.
- Reset mid-operation: all queued messages are discarded, drop_count clears, and ostream_val drops to 0 after the reset edge.
- The reset edge ignores any concurrent istream or ostream handshakes.

Test Plan:
- Unicast fan-out: noutputs=4, nbits=32, sel=[31:30], bcast_bit=29; send 0x0000_0011, 0x4000_0022, 0x8000_0033, 0xC000_0044 with all rdy=1 -> each appears on outputs 0..3 respectively one cycle after acceptance; others stay val=0.
- HOL avoidance: hold ostream_rdy[1]=0, qdepth=4; send five messages to output 1, then one to output 2 -> first four accepted, istream_rdy=0 on the fifth. Then change msg to an output-2 message -> istream_rdy=1 and output 2 delivers it while output 1 still holds four.
- Broadcast all-or-nothing: fill FIFO[3] (rdy[3]=0, four messages); present 0x2000_00AA -> istream_rdy=0. Raise rdy[3] for one cycle -> next cycle accepted, 0x2000_00AA appears on all four outputs; no output receives it twice.
- Out-of-range drop: noutputs=3; send sel=3 (0xC000_0001) three times -> istream_rdy=1, no output val, drop_count=3. With cnt_nbits=2, a fourth drop leaves drop_count=3 (saturated).
- Full with simultaneous dequeue: FIFO[0] full, rdy[0]=1, new message to output 0 -> not accepted that cycle, accepted the next; output order preserved; wrap-around verified over 10 messages.
- Reset mid-stream: three messages queued on output 2, drop_count=1; assert reset one cycle -> next cycle all ostream_val=0, drop_count=0, istream_rdy=1, and stale data is never delivered.

Source files
------------

// File: rtl/router_buffered.sv
// router_buffered: 1-to-N stream router with an independent FIFO per output.
//
// An incoming message is steered by a select field (msg[sel_lsb +: SW]) into
// the FIFO of one output, or into every FIFO at once when the broadcast bit is
// set.  Messages whose select value has no matching output are accepted and
// discarded, and a saturating drop counter records them.  Each output has its
// own queue, so a stalled output only blocks traffic headed for that output.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   istream_*      single input stream (val/rdy/msg)
//   ostream_*      per-output streams, packed [noutputs-1:0]
//   drop_count     saturating count of discarded out-of-range messages

// router_fifo: one output lane.  This is a circular buffer with head/tail
// pointers and an occupancy count.  The parent only asserts enq when the FIFO
// is not full, and only asserts deq when it is not empty.
module router_fifo #(
    parameter int nbits  = 32,
    parameter int qdepth = 4,
    localparam int PW    = $clog2(qdepth),
    localparam int CW    = $clog2(qdepth + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq,
    input  logic [nbits-1:0] enq_msg,
    input  logic             deq,
    output logic [CW-1:0]    count,
    output logic [nbits-1:0] head_msg
);
    localparam logic [PW-1:0] LAST = PW'(qdepth - 1);

    logic [qdepth-1:0][nbits-1:0] mem_q, mem_d;
    logic [PW-1:0]                head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]                count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            mem_d[tail_q] = enq_msg;
            // Explicit wrap: qdepth need not be a power of two.
            tail_d = (tail_q == LAST) ? '0 : tail_q + 1'b1;
        end
        if (deq) begin
            head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: nothing is read until count says it is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count    = count_q;
    assign head_msg = mem_q[head_q];
endmodule

module router_buffered #(
    parameter int nbits     = 32,
    parameter int noutputs  = 8,
    parameter int qdepth    = 4,
    parameter int sel_lsb   = nbits - $clog2(noutputs),
    parameter int bcast_en  = 1,
    parameter int bcast_bit = nbits - $clog2(noutputs) - 1,
    parameter int cnt_nbits = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               istream_val,
    input  logic [nbits-1:0]                   istream_msg,
    output logic                               istream_rdy,
    output logic [noutputs-1:0]                ostream_val,
    output logic [noutputs-1:0][nbits-1:0]     ostream_msg,
    input  logic [noutputs-1:0]                ostream_rdy,
    output logic [cnt_nbits-1:0]               drop_count
);
    localparam int SW = $clog2(noutputs);
    localparam int CW = $clog2(qdepth + 1);
    localparam logic [CW-1:0] DEPTH = CW'(qdepth);
    localparam logic [SW:0]   NOUT  = (SW + 1)'(noutputs);

    logic [SW-1:0]         sel;
    logic                  bcast;
    logic                  in_range;
    logic                  xfer;
    logic                  drop;
    logic [noutputs-1:0]   full;
    logic [noutputs-1:0]   enq;
    logic [noutputs-1:0]   deq;
    logic [cnt_nbits-1:0]  drop_count_q, drop_count_d;

    assign sel      = istream_msg[sel_lsb +: SW];
    assign bcast    = (bcast_en != 0) && istream_msg[bcast_bit];
    assign in_range = {1'b0, sel} < NOUT;

    // Ready depends only on the message and FIFO state, never on valid, so
    // the producer may legally wait for ready before raising valid.
    always_comb begin
        istream_rdy = 1'b1;
        if (bcast)
            istream_rdy = ~|full;
        else if (in_range)
            istream_rdy = ~full[sel];
    end

    assign xfer = istream_val && istream_rdy;
    assign drop = xfer && !bcast && !in_range;

    genvar i;
    generate
        for (i = 0; i < noutputs; i++) begin : g_lane
            logic [CW-1:0] count;

            assign full[i] = (count == DEPTH);
            assign enq[i]  = xfer && (bcast || (in_range && sel == SW'(i)));
            assign ostream_val[i] = (count != '0);
            assign deq[i]  = ostream_val[i] && ostream_rdy[i];

            router_fifo #(
                .nbits  (nbits),
                .qdepth (qdepth)
            ) u_fifo (
                .clk      (clk),
                .reset    (reset),
                .enq      (enq[i]),
                .enq_msg  (istream_msg),
                .deq      (deq[i]),
                .count    (count),
                .head_msg (ostream_msg[i])
            );
        end
    endgenerate

    always_comb begin
        drop_count_d = drop_count_q;
        if (drop && drop_count_q != '1)
            drop_count_d = drop_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            drop_count_q <= '0;
        else
            drop_count_q <= drop_count_d;
    end

    assign drop_count = drop_count_q;
endmodule

// File: tb/tb_router_buffered.sv
// Bench for router_buffered (3 outputs, depth-4 FIFOs, 2-bit drop counter):
// directed scenarios with literal expectations, then random traffic, all
// compared every cycle against a queue-based model of the routing rules.
module tb_router_buffered;
    localparam int NB = 32;
    localparam int NO = 3;
    localparam int QD = 4;
    localparam int CN = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 istream_val = 1'b0;
    logic [NB-1:0]        istream_msg = '0;
    logic                 istream_rdy;
    logic [NO-1:0]        ostream_val;
    logic [NO-1:0][NB-1:0] ostream_msg;
    logic [NO-1:0]        ostream_rdy = '1;
    logic [CN-1:0]        drop_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    logic [NB-1:0] mq [NO][$];
    int            mdrop = 0;

    router_buffered #(
        .nbits(NB), .noutputs(NO), .qdepth(QD), .sel_lsb(30),
        .bcast_en(1), .bcast_bit(29), .cnt_nbits(CN)
    ) dut (
        .clk(clk), .reset(reset),
        .istream_val(istream_val), .istream_msg(istream_msg),
        .istream_rdy(istream_rdy),
        .ostream_val(ostream_val), .ostream_msg(ostream_msg),
        .ostream_rdy(ostream_rdy),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model readiness straight from the routing rules.
    function automatic bit m_rdy(input logic [NB-1:0] m);
        int s = int'(m[31:30]);
        if (m[29]) begin
            for (int k = 0; k < NO; k++) if (mq[k].size() >= QD) return 0;
            return 1;
        end
        if (s < NO) return mq[s].size() < QD;
        return 1;
    endfunction

    // Model state update on every rising edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NO; k++) mq[k].delete();
            mdrop = 0;
            chk_en = 1;
        end else begin
            bit acc;
            int s;
            acc = istream_val && m_rdy(istream_msg);
            s = int'(istream_msg[31:30]);
            for (int k = 0; k < NO; k++)
                if (mq[k].size() != 0 && ostream_rdy[k]) void'(mq[k].pop_front());
            if (acc) begin
                if (istream_msg[29]) begin
                    for (int k = 0; k < NO; k++) mq[k].push_back(istream_msg);
                end else if (s < NO) begin
                    mq[s].push_back(istream_msg);
                end else if (mdrop < (1 << CN) - 1) begin
                    mdrop++;
                end
            end
        end
    end

    // Compare process: every falling edge once the DUT has seen reset.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("istream_rdy", 32'(istream_rdy), 32'(m_rdy(istream_msg)));
            chk("drop_count", 32'(drop_count), 32'(mdrop));
            for (int k = 0; k < NO; k++) begin
                chk($sformatf("ostream_val[%0d]", k), 32'(ostream_val[k]), 32'(mq[k].size() != 0));
                if (mq[k].size() != 0)
                    chk($sformatf("ostream_msg[%0d]", k), ostream_msg[k], mq[k][0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NB-1:0] m);
        istream_val = 1'b1;
        istream_msg = m;
        step();
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        chk("reset istream_rdy", 32'(istream_rdy), 32'd1);
        chk("reset ostream_val", 32'(ostream_val), 32'd0);
        chk("reset drop_count", 32'(drop_count), 32'd0);

        // Unicast fan-out
        ostream_rdy = 3'b111;
        send(32'h0000_0011);
        chk("uni0 val", 32'(ostream_val), 32'b001);
        chk("uni0 msg", ostream_msg[0], 32'h0000_0011);
        send(32'h4000_0022);
        chk("uni1 val", 32'(ostream_val), 32'b010);
        chk("uni1 msg", ostream_msg[1], 32'h4000_0022);
        send(32'h8000_0033);
        chk("uni2 val", 32'(ostream_val), 32'b100);
        chk("uni2 msg", ostream_msg[2], 32'h8000_0033);
        istream_val = 1'b0;
        step();

        // Head-of-line avoidance
        ostream_rdy = 3'b101;
        for (int k = 1; k <= 4; k++) send(32'h4000_0000 + k);
        istream_msg = 32'h4000_0005;
        #1;
        chk("hol full rdy", 32'(istream_rdy), 32'd0);
        step();
        istream_msg = 32'h8000_0077;
        #1;
        chk("hol other rdy", 32'(istream_rdy), 32'd1);
        step();
        istream_val = 1'b0;
        chk("hol out2 msg", ostream_msg[2], 32'h8000_0077);
        chk("hol out1 head", ostream_msg[1], 32'h4000_0001);
        chk("hol val", 32'(ostream_val), 32'b110);
        ostream_rdy = 3'b111;
        repeat (6) step();

        // Broadcast all-or-nothing
        ostream_rdy = 3'b011;
        for (int k = 0; k < 4; k++) send(32'h8000_0010 + k);
        istream_msg = 32'h2000_00AA;
        #1;
        chk("bc blocked", 32'(istream_rdy), 32'd0);
        step();
        ostream_rdy = 3'b111;
        #1;
        chk("bc no pass-through", 32'(istream_rdy), 32'd0);
        step();
        ostream_rdy = 3'b011;
        #1;
        chk("bc freed", 32'(istream_rdy), 32'd1);
        step();
        istream_val = 1'b0;
        chk("bc out0", ostream_msg[0], 32'h2000_00AA);
        chk("bc out1", ostream_msg[1], 32'h2000_00AA);
        step();
        chk("bc once", 32'(ostream_val[1:0]), 32'd0);
        ostream_rdy = 3'b111;
        repeat (6) step();

        // Out-of-range drop and saturation
        repeat (3) send(32'hC000_0001);
        chk("drop count3", 32'(drop_count), 32'd3);
        chk("drop no val", 32'(ostream_val), 32'd0);
        send(32'hC000_0001);
        chk("drop saturated", 32'(drop_count), 32'd3);
        istream_val = 1'b0;
        step();

        // Full with simultaneous dequeue, wrap-around over 10 messages
        ostream_rdy = 3'b110;
        for (int k = 0; k < 4; k++) send(32'h0000_0100 + k);
        ostream_rdy = 3'b111;
        istream_msg = 32'h0000_0104;
        #1;
        chk("full deq rdy", 32'(istream_rdy), 32'd0);
        step();
        chk("full next rdy", 32'(istream_rdy), 32'd1);
        chk("full head", ostream_msg[0], 32'h0000_0101);
        for (int k = 4; k < 10; k++) send(32'h0000_0100 + k);
        istream_val = 1'b0;
        repeat (6) step();

        // Reset mid-stream
        reset = 1'b1;
        step();
        reset = 1'b0;
        ostream_rdy = 3'b000;
        for (int k = 0; k < 3; k++) send(32'h8000_0100 + k);
        send(32'hC000_0002);
        chk("pre-reset drop", 32'(drop_count), 32'd1);
        chk("pre-reset val", 32'(ostream_val), 32'b100);
        reset = 1'b1;
        istream_msg = 32'h4000_0001;
        ostream_rdy = 3'b111;
        step();
        reset = 1'b0;
        istream_val = 1'b0;
        #1;
        chk("post-reset val", 32'(ostream_val), 32'd0);
        chk("post-reset drop", 32'(drop_count), 32'd0);
        chk("post-reset rdy", 32'(istream_rdy), 32'd1);
        repeat (3) step();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [NB-1:0] m;
            m = $urandom;
            if ($urandom_range(9) != 0) m[29] = 1'b0;
            istream_msg = m;
            istream_val = ($urandom_range(3) != 0);
            ostream_rdy = NO'($urandom);
            reset = ($urandom_range(299) == 0);
            step();
        end
        reset = 1'b0;
        istream_val = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
